// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle of the memory-stage SRAM controller.
// The master launches loads/stores; the slave (controller) returns data and ready.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: a 32-bit word access becomes two 16-bit SRAM
// accesses (low half, then high half), freezing the pipeline while busy.
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic        write_reg;
    logic [15:0] low_buf_reg;
    logic [31:0] read_data_reg;
    logic [17:0] sram_addr_reg;

    logic [16:0] word_idx;
    logic        last_cycle;
    logic        request;
    logic        drive;
    logic [15:0] dq_out;

    assign word_idx   = 17'((addr_reg - BASE_ADDR) >> 2);
    assign last_cycle = (cnt_reg == 4'(WAIT_CYCLES - 1));
    assign request    = bus.rd_en | bus.wr_en;

    // The controller only drives the bus during write halves; otherwise the SRAM owns it.
    assign SRAM_DQ       = drive ? dq_out : 16'hzzzz;
    assign bus.read_data = read_data_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bus.ready  = 1'b1;
        SRAM_ADDR  = sram_addr_reg;
        SRAM_WE_N  = 1'b1;
        drive      = 1'b0;
        dq_out     = data_reg[15:0];
        case (state_reg)
            IDLE: begin
                bus.ready = ~request;
                if (request) begin
                    state_next = LOW;
                    cnt_next   = 4'd0;
                end
            end
            LOW: begin
                bus.ready = 1'b0;
                SRAM_ADDR = {word_idx, 1'b0};
                SRAM_WE_N = ~write_reg;
                drive     = write_reg;
                if (last_cycle) begin
                    cnt_next   = 4'd0;
                    state_next = HIGH;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HIGH: begin
                bus.ready = 1'b0;
                SRAM_ADDR = {word_idx, 1'b1};
                SRAM_WE_N = ~write_reg;
                drive     = write_reg;
                dq_out    = data_reg[31:16];
                if (last_cycle) begin
                    cnt_next   = 4'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= 32'd0;
            data_reg      <= 32'd0;
            write_reg     <= 1'b0;
            low_buf_reg   <= 16'd0;
            read_data_reg <= 32'd0;
            sram_addr_reg <= 18'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sram_addr_reg <= SRAM_ADDR;
            // Write wins when both enables are asserted.
            if (state_reg == IDLE && request) begin
                addr_reg  <= bus.address;
                data_reg  <= bus.write_data;
                write_reg <= bus.wr_en;
            end
            if (state_reg == LOW && !write_reg && last_cycle)
                low_buf_reg <= SRAM_DQ;
            if (state_reg == HIGH && !write_reg && last_cycle)
                read_data_reg <= {SRAM_DQ, low_buf_reg};
        end
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage SRAM controller for the five-stage pipeline. It consumes the memory-read and memory-write enables, the ALU-computed address and the store data that the decode stage launches down the pipeline. It performs a 32-bit word access as two 16-bit accesses on the external SRAM. While an access is in flight it drops `ready` so the pipeline freezes, and it returns the loaded word to the write-back path.

## Interface

Parameters:
- `WAIT_CYCLES`, default 2: clock cycles spent on each 16-bit half access; legal range 1–15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  memory read request (MEM_R_EN of the memory stage).
- `wr_en`  in  1  memory write request (MEM_W_EN of the memory stage).
- `address`  in  32  byte address from the ALU; word aligned.
- `write_data`  in  32  store data.
- `read_data`  out  32  loaded word; holds its value between reads.
- `ready`  out  1  high = no access pending, pipeline may advance; low = freeze.
- `SRAM_DQ`  inout  16  SRAM data bus; driven only while writing, else high-Z.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  SRAM write enable, active low.

## Operation

- Address map:
  - `word_idx = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - `SRAM_ADDR = {word_idx[16:0], half}`, where `half` = 0 for bits [15:0] and 1 for bits [31:16].
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If `wr_en` or `rd_en` is high, latch `address`, `write_data` and the op type, then go to LOW with the wait counter at 0.
  - If both enables are high, perform a write.
  - Requests are sampled only in IDLE. Input changes in any other state are ignored.
- LOW:
  - Drive `SRAM_ADDR` with `half`=0.
  - Write: `SRAM_WE_N`=0, `SRAM_DQ` = latched data[15:0].
  - Read: `SRAM_WE_N`=1, `SRAM_DQ` = Z. On the last cycle (counter = `WAIT_CYCLES`-1), capture `SRAM_DQ` into a low-half buffer.
  - When the counter reaches `WAIT_CYCLES`-1, clear it and go to HIGH. Otherwise increment.
- HIGH:
  - Same as LOW with `half`=1 and data[31:16].
  - On the last cycle, a read updates `read_data` to {`SRAM_DQ`, low-half buffer}. Then go to DONE.
- DONE: `SRAM_WE_N`=1, `SRAM_DQ` = Z, go to IDLE unconditionally.
- `ready`:
  - Combinational.
  - In IDLE: `ready = ~(rd_en | wr_en)`.
  - In LOW and HIGH: 0.
  - In DONE: 1.
- A write never modifies `read_data`.
- Outputs in IDLE and DONE: `SRAM_ADDR` holds its last value, `SRAM_WE_N`=1, `SRAM_DQ` = Z.

## Timing

- Request first seen high in IDLE at cycle t:
  - `ready` is low during cycles t … t+2·`WAIT_CYCLES`.
  - `ready` is high at cycle t+2·`WAIT_CYCLES`+1 (DONE).
  - With the default, low during t..t+4 and high at t+5.
- `read_data` updates at the clock edge that enters DONE, so it is valid during the `ready`-high cycle.
- During a write, `SRAM_WE_N` is low for exactly 2·`WAIT_CYCLES` consecutive cycles. Address and data are stable throughout each half.
- Back-to-back: a new request presented in the IDLE cycle that follows DONE starts immediately. The minimum spacing between access starts is 2·`WAIT_CYCLES`+2 cycles.
- Reset values, in any state: FSM = IDLE, counter = 0, `read_data` = 0, `SRAM_ADDR` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` = Z. `ready` then follows the IDLE rule.
- Reset mid-access aborts the access. A partially written word is left as is, and no `read_data` update occurs.

## Test plan

- Write then read: with `write_data`=0xDEADBEEF at `address`=1028, expect
  - SRAM half 2 = 0xBEEF and half 3 = 0xDEAD;
  - after a read of 1028, `read_data`=0xDEADBEEF with `ready` high exactly 5 cycles after the request (default `WAIT_CYCLES`).
- Freeze timing: hold `rd_en` high and count `ready`-low cycles. Expect exactly 5 for `WAIT_CYCLES`=2 and exactly 3 for `WAIT_CYCLES`=1. `SRAM_WE_N` stays 1 throughout.
- Input change while busy: change `address` from 1024 to 1040 two cycles into a write. The write still lands at `SRAM_ADDR` 0 and 1; halves 8 and 9 are unchanged.
- Both enables high: `rd_en`=`wr_en`=1 with data 0x12345678 at 1024. Expect a write of 0x5678/0x1234 to `SRAM_ADDR` 0/1, and `read_data` unchanged.
- Reset mid-read: assert `rst` for one cycle during HIGH of a read of a word holding 0xCAFEF00D. Expect FSM in IDLE, `read_data`=0, `SRAM_WE_N`=1 and `SRAM_DQ` = Z at the next cycle, and `ready` high once `rd_en` is low.
- Back-to-back: write 0xA5A5A5A5 to 1032, then read 1032 in the cycle after DONE. The read starts with no idle gap and returns 0xA5A5A5A5.
